weighted_rr_bus_arbiter: RTL and testbench

//  Transaction-level weighted round-robin arbiter for the shared snoop/memory bus.

---
 rtl/weighted_rr_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_weighted_rr_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_bus_arbiter.sv
// weighted_rr_bus_arbiter
// Transaction-level weighted round-robin arbiter for the shared snoop/memory bus.
// One requester at a time holds a registered one-hot grant until it reports done.
// A holder may keep the bus for up to weight[i] back-to-back transactions while
// others wait. After that the round-robin pointer moves past it.
// Optional feature: define ARB_TIMEOUT_EN to build a watchdog. The watchdog
// revokes a holder that goes TIMEOUT_CYCLES busy cycles without a done pulse.
module weighted_rr_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WEIGHT_W       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            done,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_n;
    logic [NUM_REQ-1:0]    grant_n;
    logic [IDW-1:0]        id_n;
    logic [IDW-1:0]        ptr_q, ptr_n;
    logic [WEIGHT_W-1:0]   cred_q, cred_n;
    logic [WEIGHT_W-1:0]   wt [NUM_REQ];
    logic                  release_h;
    logic [NUM_REQ-1:0]    masked;
    logic [IDW-1:0]        win;

    // A zero weight still allows one transaction per turn.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    // First set request at or above p, wrapping modulo NUM_REQ.
    function automatic logic [IDW-1:0] arb_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDW-1:0]     p);
        logic [IDW-1:0] pick;
        logic           hit;
        int             j;
        pick = '0;
        hit  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(p) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!hit && r[j]) begin
                hit  = 1'b1;
                pick = IDW'(j);
            end
        end
        return pick;
    endfunction

    // Unpack the weight bus into per-requester fields.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wt
        assign wt[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end

    assign busy = (state_q == BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_q, wd_n;
    logic           wd_expired;
    logic           timeout_hit;
    logic           terr_n;

    // The current edge closes the last allowed busy cycle without a done.
    assign wd_expired = (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, grant, credit and pointer decisions.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant;
        id_n      = grant_id;
        ptr_n     = ptr_q;
        cred_n    = cred_q;
        release_h = 1'b0;
        masked    = '0;
        win       = '0;
`ifdef ARB_TIMEOUT_EN
        wd_n        = wd_q;
        timeout_hit = 1'b0;
        terr_n      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win     = arb_pick(req, ptr_q);
                    state_n = BUSY;
                    grant_n = NUM_REQ'(1) << win;
                    id_n    = win;
                    cred_n  = eff_weight(wt[win]);
`ifdef ARB_TIMEOUT_EN
                    wd_n    = '0;
`endif
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                wd_n = wd_q + 1'b1;
`endif
                if (!req[grant_id]) begin
                    // Holder withdrew its request: give the bus up now.
                    release_h = 1'b1;
                end else if (done[grant_id]) begin
`ifdef ARB_TIMEOUT_EN
                    wd_n = '0;
`endif
                    if (cred_q > WEIGHT_W'(1)) begin
                        cred_n = cred_q - 1'b1;
                    end else if (|(req & ~grant)) begin
                        release_h = 1'b1;
                    end else begin
                        // Nobody else waiting: start a fresh quota.
                        cred_n = eff_weight(wt[grant_id]);
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    release_h   = 1'b1;
                    timeout_hit = 1'b1;
                end
`endif
                if (release_h) begin
                    ptr_n  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                    masked = req & ~grant;
`ifdef ARB_TIMEOUT_EN
                    wd_n   = '0;
                    terr_n = timeout_hit;
`endif
                    if (|masked) begin
                        // Hand over directly, no idle bubble.
                        win     = arb_pick(masked, ptr_n);
                        grant_n = NUM_REQ'(1) << win;
                        id_n    = win;
                        cred_n  = eff_weight(wt[win]);
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        id_n    = '0;
                        cred_n  = '0;
                    end
                end
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr_q    <= '0;
            cred_q   <= '0;
        end else begin
            state_q  <= state_n;
            grant    <= grant_n;
            grant_id <= id_n;
            ptr_q    <= ptr_n;
            cred_q   <= cred_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and the one-cycle revoke flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_q        <= wd_n;
            timeout_err <= terr_n;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_weighted_rr_bus_arbiter.sv
// Testbench for weighted_rr_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_weighted_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N*WW-1:0] weight;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weighted_rr_bus_arbiter #(
        .NUM_REQ(N), .WEIGHT_W(WW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .weight(weight),
        .grant(grant), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    // Reference model: who holds the bus, remaining quota, rotation pointer.
    int m_holder;
    int m_creds;
    int m_ptr;
    int m_wd;
    bit m_terr;

    function automatic int eff(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_holder = -1; m_creds = 0; m_ptr = 0; m_wd = 0; m_terr = 0;
        end else begin : step
            int h;
            bit rel;
            bit to;
            logic [N-1:0] others;
            h = m_holder; rel = 0; to = 0; m_terr = 0;
            if (h < 0) begin
                if (req != 0) begin
                    m_holder = first_from(req, m_ptr);
                    m_creds  = eff(m_holder);
                    m_wd     = 0;
                end
            end else begin
                others = req;
                others[h] = 1'b0;
                if (!req[h]) rel = 1;
                else if (done[h]) begin
                    m_wd = 0;
                    if (m_creds > 1) m_creds = m_creds - 1;
                    else if (others != 0) rel = 1;
                    else m_creds = eff(h);
                end else begin
                    m_wd = m_wd + 1;
                    if (TO_EN && m_wd >= TO) begin rel = 1; to = 1; end
                end
                if (rel) begin
                    m_ptr    = (h + 1) % N;
                    m_wd     = 0;
                    m_terr   = to;
                    m_holder = first_from(others, m_ptr);
                    m_creds  = (m_holder >= 0) ? eff(m_holder) : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [N-1:0] r, input logic [N*WW-1:0] w);
        rst = 1'b1; req = r; done = '0; weight = w;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = '0; weight = 16'h1111;
        tick(); tick();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        rst = 1'b0;
        tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
        total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL reset_first_id: busy=%b id=%0d want busy=1 id=0", busy, grant_id); end
    endtask

    task automatic test_equal_rr();
        logic [N-1:0] exp [5];
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        start(4'b1111, 16'h1111);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (grant !== exp[k] || busy !== 1'b1) begin
                bad++; $display("FAIL equal_rr[%0d]: got grant=%b busy=%b want %b busy=1", k, grant, busy, exp[k]);
            end
            done = exp[k];
        end
        done = '0;
    endtask

    task automatic test_weighted();
        logic [N-1:0] exp [8];
        exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        start(4'b0011, 16'h1113);
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (grant !== exp[k]) begin
                bad++; $display("FAIL weighted[%0d]: got %b want %b", k, grant, exp[k]);
            end
            done = exp[k];
        end
        done = '0;
    endtask

    task automatic test_single_reload();
        start(4'b0100, 16'h0200);
        tick();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (grant !== 4'b0100 || busy !== 1'b1 || grant_id !== 2'd2) begin
                bad++; $display("FAIL reload[%0d]: got grant=%b busy=%b id=%0d want 0100 1 2", k, grant, busy, grant_id);
            end
            done = 4'b0100;
            tick();
        end
        done = '0;
    endtask

    task automatic test_drop_and_stray_done();
        start(4'b0010, 16'h1111);
        tick();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL drop_setup: got %b want 0010", grant); end
        req = 4'b1010; done = 4'b0001;
        tick();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL stray_done: got %b want 0010", grant); end
        req = 4'b1000; done = '0;
        tick();
        total++; if (grant !== 4'b1000 || grant_id !== 2'd3) begin bad++; $display("FAIL drop_req: got %b id=%0d want 1000 id=3", grant, grant_id); end
    endtask

    task automatic test_timeout();
        logic [N-1:0] eg;
        logic         et;
        start(4'b0011, 16'h1111);
        tick();
        for (int c = 1; c <= 12; c++) begin
            tick();
            eg = (TO_EN && c >= TO) ? 4'b0010 : 4'b0001;
            et = TO_EN && (c == TO);
            total++;
            if (grant !== eg || timeout_err !== et) begin
                bad++; $display("FAIL timeout[%0d]: got grant=%b terr=%b want %b %b", c, grant, timeout_err, eg, et);
            end
        end
    endtask

    task automatic test_async_reset();
        start(4'b0101, 16'h1111);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL async_reset: got grant=%b busy=%b id=%0d terr=%b want all 0", grant, busy, grant_id, timeout_err);
        end
        tick();
        rst = 1'b0;
        tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL async_reset_regrant: got %b want 0001", grant); end
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        start(4'b0000, 16'h1111);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            done = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 9) == 0) weight = (N*WW)'($urandom);
            tick();
            eg = (m_holder < 0) ? '0 : (N'(1) << m_holder);
            total++;
            if (grant !== eg || busy !== (m_holder >= 0) || timeout_err !== m_terr ||
                (m_holder >= 0 && int'(grant_id) != m_holder)) begin
                bad++;
                $display("FAIL random[%0d]: got grant=%b busy=%b id=%0d terr=%b want grant=%b holder=%0d terr=%b",
                         c, grant, busy, grant_id, timeout_err, eg, m_holder, m_terr);
            end
        end
        done = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0; weight = '0;
        test_reset();
        test_equal_rr();
        test_weighted();
        test_single_reload();
        test_drop_and_stray_done();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
